// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared definitions for the universal shift register.
//               - usr_mode_e    : operation select encoding
//               - usr_cnt_width : width of a counter that must reach WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_e;

    // Bits needed to represent every value 0..width inclusive.
    function automatic int usr_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usr_cell.sv
`default_nettype none
// ============================================================================
// Module      : usr_cell
// Description : One bit of the universal register: a flop behind a 4:1
//               next-state mux (hold / from higher bit / from lower bit /
//               load).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_rst_val     - value taken on reset
//               i_en          - clock enable
//               i_mode        - operation select (usr_mode_e encoding)
//               i_from_hi     - bit arriving on a right shift
//               i_from_lo     - bit arriving on a left shift
//               i_load_d      - parallel load bit
//               o_q           - stored bit
// Revision    : 1.0 - initial release
// ============================================================================
module usr_cell
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rst_val,
    input  logic       i_en,
    input  logic [1:0] i_mode,
    input  logic       i_from_hi,
    input  logic       i_from_lo,
    input  logic       i_load_d,
    output logic       o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= i_rst_val;
        end else if (i_en) begin
            case (usr_mode_e'(i_mode))
                USR_SHR:  r_q <= i_from_hi;
                USR_SHL:  r_q <= i_from_lo;
                USR_LOAD: r_q <= i_load_d;
                // HOLD, and any unknown mode, keeps the bit.
                default:  r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Parametrised universal register: hold, shift-right,
//               shift-left and parallel load, with true/complement outputs,
//               serial outputs and a shift counter saturating at WIDTH.
//               Build option USR_ROTATE_EN: shifts become rotates and the
//               serial inputs are ignored.
// Parameters  : WIDTH   - register width (>= 2)
//               RST_VAL - value of q after reset
// Ports       : clk, rst           - clock, synchronous active-high reset
//               en                 - clock enable
//               mode               - 00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//               sin_msb / sin_lsb  - serial inputs for SHR / SHL
//               d                  - parallel load data
//               q / q_n            - contents and complement
//               sout_r / sout_l    - bits leaving on SHR / SHL
//               shift_cnt / full   - shifts since load/reset, at-WIDTH flag
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       sin_msb,
    input  logic                       sin_lsb,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_n,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       full
);

    localparam int                 c_cnt_w   = usr_cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("univ_shift_reg: WIDTH must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_from_hi;
    logic [WIDTH-1:0]   w_from_lo;
    logic               w_end_hi;   // enters q[WIDTH-1] on SHR
    logic               w_end_lo;   // enters q[0] on SHL
    logic [c_cnt_w-1:0] r_shift_cnt;

`ifdef USR_ROTATE_EN
    // Serial inputs are not used when shifts wrap around.
    logic w_unused_sin;
    assign w_unused_sin = sin_msb ^ sin_lsb;
    assign w_end_hi     = w_q[0];
    assign w_end_lo     = w_q[WIDTH-1];
`else
    assign w_end_hi     = sin_msb;
    assign w_end_lo     = sin_lsb;
`endif

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            if (i == WIDTH - 1) begin : g_hi_end
                assign w_from_hi[i] = w_end_hi;
            end else begin : g_hi_mid
                assign w_from_hi[i] = w_q[i+1];
            end

            if (i == 0) begin : g_lo_end
                assign w_from_lo[i] = w_end_lo;
            end else begin : g_lo_mid
                assign w_from_lo[i] = w_q[i-1];
            end

            usr_cell u_cell (
                .clk       (clk),
                .rst       (rst),
                .i_rst_val (RST_VAL[i]),
                .i_en      (en),
                .i_mode    (mode),
                .i_from_hi (w_from_hi[i]),
                .i_from_lo (w_from_lo[i]),
                .i_load_d  (d[i]),
                .o_q       (w_q[i])
            );
        end
    endgenerate

    // Counts shifts since the last load or reset, sticking at WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_cnt <= '0;
        end else if (en) begin
            case (usr_mode_e'(mode))
                USR_SHR, USR_SHL: begin
                    if (r_shift_cnt != c_cnt_max) begin
                        r_shift_cnt <= r_shift_cnt + 1'b1;
                    end
                end
                USR_LOAD: r_shift_cnt <= '0;
                default:  r_shift_cnt <= r_shift_cnt;
            endcase
        end
    end

    assign q         = w_q;
    assign q_n       = ~w_q;
    assign sout_r    = w_q[0];
    assign sout_l    = w_q[WIDTH-1];
    assign shift_cnt = r_shift_cnt;
    assign full      = (r_shift_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg (WIDTH 8,
//               RST_VAL 8'hA5). Directed scenarios plus a randomized run
//               checked against a behavioural word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, en, sin_msb, sin_lsb;
    logic [1:0] mode;
    logic [7:0] d, q, q_n;
    logic       sout_r, sout_l, full;
    logic [3:0] shift_cnt;

    int         n_cmp = 0;
    int         n_err = 0;

    // Behavioural model state
    logic [7:0] m_q;
    int         m_cnt;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W), .RST_VAL(RSTV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_msb   (sin_msb),
        .sin_lsb   (sin_lsb),
        .d         (d),
        .q         (q),
        .q_n       (q_n),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .full      (full)
    );

    // Complement invariant, sampled away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if (q_n !== ~q) begin
            n_err++;
            $display("FAIL q_n_invariant: q_n=%h required=%h", q_n, ~q);
        end
    end

    // An unknown mode while enabled is an error on the bench side.
    always @(posedge clk) begin
        if (en === 1'b1 && $isunknown(mode)) begin
            n_err++;
            $display("FAIL x_mode: mode=%b while en=1", mode);
        end
    end

    // Drive one cycle of inputs, wait for the edge, advance the model.
    task automatic cycle(input logic r, input logic e, input logic [1:0] md,
                         input logic smsb, input logic slsb, input logic [7:0] dd);
        rst = r; en = e; mode = md; sin_msb = smsb; sin_lsb = slsb; d = dd;
        @(posedge clk);
        #1;
        if (r) begin
            m_q   = RSTV;
            m_cnt = 0;
        end else if (e) begin
            case (md)
                2'd1: begin
`ifdef USR_ROTATE_EN
                    m_q = (m_q >> 1) | (m_q << 7);
`else
                    m_q = (m_q >> 1) | (8'(smsb) << 7);
`endif
                    if (m_cnt < W) m_cnt = m_cnt + 1;
                end
                2'd2: begin
`ifdef USR_ROTATE_EN
                    m_q = (m_q << 1) | (m_q >> 7);
`else
                    m_q = (m_q << 1) | 8'(slsb);
`endif
                    if (m_cnt < W) m_cnt = m_cnt + 1;
                end
                2'd3: begin
                    m_q   = dd;
                    m_cnt = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, 2'd0, 0, 0, 8'h00);
        cycle(1, 1, 2'd3, 1, 1, 8'hFF);
        n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL reset_q: got %h want a5", q); end
        n_cmp++; if (q_n !== 8'h5A) begin n_err++; $display("FAIL reset_q_n: got %h want 5a", q_n); end
        n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", shift_cnt); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    endtask

    task automatic test_load_hold();
        cycle(0, 1, 2'd3, 0, 0, 8'h3C);
        for (int i = 0; i < 3; i++) cycle(0, 1, 2'd0, 1, 1, 8'hFF);
        for (int i = 0; i < 2; i++) cycle(0, 0, 2'd1, 1, 1, 8'hFF);
        n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL load_hold_q: got %h want 3c", q); end
        n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL load_hold_cnt: got %0d want 0", shift_cnt); end
    endtask

    task automatic test_shift_right();
        logic [7:0] seq;
        logic [7:0] q_exp;
        seq = 8'b1000_0001;
`ifdef USR_ROTATE_EN
        q_exp = 8'h81;
`else
        q_exp = 8'h00;
`endif
        cycle(0, 1, 2'd3, 0, 0, 8'h81);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (sout_r !== seq[k]) begin
                n_err++; $display("FAIL shr_sout_r[%0d]: got %b want %b", k, sout_r, seq[k]);
            end
            cycle(0, 1, 2'd1, 0, 0, 8'h00);
        end
        n_cmp++; if (q !== q_exp) begin n_err++; $display("FAIL shr_q: got %h want %h", q, q_exp); end
        n_cmp++; if (shift_cnt !== 4'd8) begin n_err++; $display("FAIL shr_cnt: got %0d want 8", shift_cnt); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL shr_full: got %b want 1", full); end
        cycle(0, 1, 2'd1, 0, 0, 8'h00);
        n_cmp++; if (shift_cnt !== 4'd8) begin n_err++; $display("FAIL shr_saturate: got %0d want 8", shift_cnt); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL shr_sat_full: got %b want 1", full); end
    endtask

    task automatic test_shift_left();
        logic [7:0] q_exp;
`ifdef USR_ROTATE_EN
        q_exp = 8'h00;
`else
        q_exp = 8'h07;
`endif
        cycle(0, 1, 2'd3, 0, 0, 8'h00);
        for (int k = 0; k < 3; k++) cycle(0, 1, 2'd2, 0, 1, 8'h00);
        n_cmp++; if (q !== q_exp) begin n_err++; $display("FAIL shl_q: got %h want %h", q, q_exp); end
        n_cmp++; if (shift_cnt !== 4'd3) begin n_err++; $display("FAIL shl_cnt: got %0d want 3", shift_cnt); end
        n_cmp++; if (sout_l !== 1'b0) begin n_err++; $display("FAIL shl_sout_l: got %b want 0", sout_l); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL shl_full: got %b want 0", full); end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 2'd3, 0, 0, 8'hFF);
        cycle(0, 1, 2'd1, 0, 0, 8'h00);
        cycle(0, 1, 2'd1, 0, 0, 8'h00);
        cycle(1, 1, 2'd1, 0, 0, 8'h00);
        n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL rst_mid_q: got %h want a5", q); end
        n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", shift_cnt); end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        logic [7:0] q_exp;
        cycle(0, 1, 2'd3, 0, 0, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 1, 2'd2, 0, 1, 8'h00);
            q_exp = 8'h01 << (k % 8);
            n_cmp++;
            if (q !== q_exp) begin n_err++; $display("FAIL rotl_q[%0d]: got %h want %h", k, q, q_exp); end
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL rotl_full: got %b want 1", full); end
    endtask
`endif

    task automatic test_random();
        logic       r, e, smsb, slsb;
        logic [1:0] md;
        logic [7:0] dd;
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            e    = ($urandom_range(0, 4) != 0);
            md   = 2'($urandom_range(0, 3));
            // Favour shifts so the counter regularly saturates.
            if ($urandom_range(0, 2) != 0 && md == 2'd3) md = 2'($urandom_range(1, 2));
            smsb = 1'($urandom);
            slsb = 1'($urandom);
            dd   = 8'($urandom);
            cycle(r, e, md, smsb, slsb, dd);
            n_cmp++;
            if (q !== m_q || q_n !== ~m_q || sout_r !== m_q[0] || sout_l !== m_q[7] ||
                shift_cnt !== 4'(m_cnt) || full !== (m_cnt == W)) begin
                n_err++;
                $display("FAIL random[%0d]: q=%h cnt=%0d full=%b sr=%b sl=%b required q=%h cnt=%0d full=%b",
                         i, q, shift_cnt, full, sout_r, sout_l, m_q, m_cnt, (m_cnt == W));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; sin_msb = 1'b0; sin_lsb = 1'b0; d = 8'h00;
        m_q = RSTV; m_cnt = 0;
        test_reset();
        test_load_hold();
        test_shift_right();
        test_shift_left();
        test_reset_mid();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
